// File: rtl/axi_rd_mgr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_pkg / axi_if                                                           |
// | AXI4 burst/response encodings and the AR/R channel bundle used by the read |
// | manager.                                                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package axi_pkg;
    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;
endpackage

interface axi_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 8,
    parameter int UW = 32
) ();
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [UW-1:0] aruser;
    logic          arvalid;
    logic          arready;

    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [UW-1:0] ruser;
    logic          rvalid;
    logic          rready;

    modport r_mgr (
        output arid, araddr, arlen, arsize, arburst, arlock, aruser, arvalid,
        input  arready,
        input  rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport r_sub (
        input  arid, araddr, arlen, arsize, arburst, arlock, aruser, arvalid,
        output arready,
        output rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

`default_nettype wire

// File: rtl/axi_rd_mgr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_mgr                                                                 |
// | Pipelined AXI4 read manager: request stream -> AR bursts, R beats -> rsp   |
// | stream, up to MAX_OUTSTANDING in-order bursts tracked by a length FIFO.    |
// | Optional rlast checking: define AXI_RD_MGR_LAST_CHECK_EN.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module axi_rd_mgr
    import axi_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int IW              = 8,
    parameter int UW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RD_ID           = 0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  axi_burst_e      req_burst,
    input  logic [2:0]      req_size,
    input  logic [7:0]      req_len,
    input  logic [UW-1:0]   req_user,
    input  logic            req_lock,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [UW-1:0]   rsp_user,
    output axi_resp_e       rsp_resp,
    output logic            rsp_last,

    output logic            idle,
    output logic            err_last,

    axi_if.r_mgr            m_axi
);

    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_CNT_W = c_OUT_W + 1;
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

    logic               arvalid_q, arvalid_d;
    logic [AW-1:0]      araddr_q,  araddr_d;
    logic [7:0]         arlen_q,   arlen_d;
    logic [2:0]         arsize_q,  arsize_d;
    logic [1:0]         arburst_q, arburst_d;
    logic               arlock_q,  arlock_d;
    logic [UW-1:0]      aruser_q,  aruser_d;

    logic [c_OUT_W-1:0] outstanding_q, outstanding_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]         len_fifo_q [MAX_OUTSTANDING];

    logic               w_ar_hs;
    logic               w_req_hs;
    logic               w_rready;
    logic               w_r_hs;
    logic               w_fifo_empty;
    logic [7:0]         w_head;
    logic               w_head_match;
    logic               w_burst_end;
    logic [c_CNT_W-1:0] w_ar_budget;

    // AR slot: a pending request counts against the outstanding budget
    always_comb begin
        w_ar_hs     = arvalid_q && m_axi.arready;
        w_ar_budget = {1'b0, outstanding_q} + {{c_OUT_W{1'b0}}, arvalid_q};
        req_ready   = rst_n && (!arvalid_q || m_axi.arready) && (w_ar_budget < c_MAX_CNT);
        w_req_hs    = req_valid && req_ready;

        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arlock_d  = arlock_q;
        aruser_d  = aruser_q;
        if (w_req_hs) begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
            arlen_d   = req_len;
            arsize_d  = req_size;
            arburst_d = req_burst;
            arlock_d  = req_lock;
            aruser_d  = req_user;
        end else if (w_ar_hs) begin
            arvalid_d = 1'b0;
        end
    end

    // FIFO occupancy is exactly the outstanding count, so no separate level
    always_comb begin
        w_rready     = rst_n && rsp_ready;
        w_r_hs       = m_axi.rvalid && w_rready;
        w_fifo_empty = (outstanding_q == '0);
        w_head       = len_fifo_q[rd_ptr_q];
        w_head_match = (bcnt_q == w_head);
        w_burst_end  = w_r_hs && !w_fifo_empty && w_head_match;

        bcnt_d = bcnt_q;
        if (w_r_hs && !w_fifo_empty) begin
            bcnt_d = w_burst_end ? 8'd0 : bcnt_q + 8'd1;
        end

        rd_ptr_d = rd_ptr_q;
        if (w_burst_end) begin
            rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + c_PTR_W'(1);
        end

        wr_ptr_d = wr_ptr_q;
        if (w_ar_hs) begin
            wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + c_PTR_W'(1);
        end

        outstanding_d = outstanding_q;
        case ({w_ar_hs, w_burst_end})
            2'b10:   outstanding_d = outstanding_q + c_OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - c_OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arsize_q      <= '0;
            arburst_q     <= AXI_BURST_FIXED;
            arlock_q      <= 1'b0;
            aruser_q      <= '0;
            outstanding_q <= '0;
            bcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            arsize_q      <= arsize_d;
            arburst_q     <= arburst_d;
            arlock_q      <= arlock_d;
            aruser_q      <= aruser_d;
            outstanding_q <= outstanding_d;
            bcnt_q        <= bcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: validity is carried by outstanding_q
    always_ff @(posedge clk) begin
        if (w_ar_hs) begin
            len_fifo_q[wr_ptr_q] <= arlen_q;
        end
    end

    assign m_axi.arid    = IW'(RD_ID);
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = arsize_q;
    assign m_axi.arburst = arburst_q;
    assign m_axi.arlock  = arlock_q;
    assign m_axi.aruser  = aruser_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = w_rready;

    assign rsp_valid = m_axi.rvalid;
    assign rsp_data  = m_axi.rdata;
    assign rsp_user  = m_axi.ruser;
    assign idle      = !arvalid_q && (outstanding_q == '0);

`ifdef AXI_RD_MGR_LAST_CHECK_EN
    logic err_last_q, err_last_d;
    logic w_exp_last;
    logic w_mismatch;

    // A beat with nothing outstanding can never match, so it is a mismatch too
    always_comb begin
        w_exp_last = !w_fifo_empty && w_head_match;
        w_mismatch = w_fifo_empty || (m_axi.rlast != w_exp_last);
        err_last_d = w_r_hs && w_mismatch;
        rsp_last   = w_exp_last;
        rsp_resp   = (m_axi.rvalid && w_mismatch) ? AXI_RESP_SLVERR : axi_resp_e'(m_axi.rresp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_last_q <= 1'b0;
        end else begin
            err_last_q <= err_last_d;
        end
    end

    assign err_last = err_last_q;
`else
    assign rsp_last = m_axi.rlast;
    assign rsp_resp = axi_resp_e'(m_axi.rresp);
    assign err_last = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_mgr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_rd_mgr                                                              |
// | Directed self-checking bench for axi_rd_mgr with a hand-driven fabric.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_axi_rd_mgr;
    import axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int UW = 32;
    localparam int MAXO = 4;
`ifdef AXI_RD_MGR_LAST_CHECK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    axi_burst_e      req_burst;
    logic [2:0]      req_size;
    logic [7:0]      req_len;
    logic [UW-1:0]   req_user;
    logic            req_lock;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [UW-1:0]   rsp_user;
    axi_resp_e       rsp_resp;
    logic            rsp_last;
    logic            idle;
    logic            err_last;

    int n_chk = 0;
    int n_err = 0;
    int ar_total = 0;
    logic [31:0] rcv_data [$];
    logic        rcv_last [$];

    always #5 clk = ~clk;

    axi_if #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) axi ();

    axi_rd_mgr #(
        .AW(AW), .DW(DW), .IW(IW), .UW(UW), .MAX_OUTSTANDING(MAXO), .RD_ID(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_burst (req_burst),
        .req_size  (req_size),
        .req_len   (req_len),
        .req_user  (req_user),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_user  (rsp_user),
        .rsp_resp  (rsp_resp),
        .rsp_last  (rsp_last),
        .idle      (idle),
        .err_last  (err_last),
        .m_axi     (axi)
    );

    // Inputs only change 1 time unit after posedge, so negedge sees what the next edge takes
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (axi.arvalid && axi.arready) ar_total++;
            if (rsp_valid && rsp_ready) begin
                rcv_data.push_back(rsp_data);
                rcv_last.push_back(rsp_last);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [31:0] addr, input logic [7:0] len);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        req_burst = AXI_BURST_INCR;
        req_size  = 3'd2;
        req_user  = addr;
        req_lock  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk(tag, ok, 1'b1);
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = AXI_RESP_OKAY;
        axi.rlast  = last;
        axi.ruser  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ready_seen;
        int bad;
        int k;
        int base;
        logic [23:0] lv;
        logic [31:0] exp_d [3];
        logic        exp_l [3];

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_burst = AXI_BURST_INCR;
        req_size = 3'd2; req_len = '0; req_user = '0; req_lock = 1'b0; rsp_ready = 1'b1;
        axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1'b0; axi.ruser = '0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_arvalid",   axi.arvalid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rready",    axi.rready, 1'b0);
        chk("rst_idle",      idle, 1'b1);
        chk("rst_err_last",  err_last, 1'b0);
        chk("rst_araddr",    axi.araddr, 32'h0);
        chk("rst_arburst",   axi.arburst, AXI_BURST_FIXED);
        step();
        rst_n = 1'b1;
        step();

        // Single read
        req_valid = 1'b1; req_addr = 32'h100; req_len = 8'd0; req_burst = AXI_BURST_INCR;
        req_size = 3'd2; req_user = 32'hA5; req_lock = 1'b0;
        @(negedge clk);
        chk("single_req_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("single_arvalid", axi.arvalid, 1'b1);
        chk("single_araddr",  axi.araddr, 32'h100);
        chk("single_arlen",   axi.arlen, 8'd0);
        chk("single_arsize",  axi.arsize, 3'd2);
        chk("single_arburst", axi.arburst, AXI_BURST_INCR);
        chk("single_arid",    axi.arid, 8'd0);
        chk("single_aruser",  axi.aruser, 32'hA5);
        chk("single_idle_busy", idle, 1'b0);
        step();
        beat(32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("single_arvalid_drop", axi.arvalid, 1'b0);
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_data",  rsp_data, 32'hDEADBEEF);
        chk("single_rsp_last",  rsp_last, 1'b1);
        chk("single_rsp_resp",  rsp_resp, AXI_RESP_OKAY);
        step();
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("single_idle_done", idle, 1'b1);
        chk("single_err_last",  err_last, 1'b0);

        // Outstanding limit: 6 requests of len 3 with R withheld
        step();
        rcv_data.delete(); rcv_last.delete();
        base = ar_total;
        for (int i = 0; i < 4; i++) issue("lim_issue", 32'h1000 + 32'(i) * 32'h10, 8'd3);
        req_valid = 1'b1; req_addr = 32'h1040; req_len = 8'd3;
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req_ready) ready_seen++;
            step();
        end
        chk("lim_ready_blocked", ready_seen, 0);
        chk("lim_ar_count4", ar_total - base, 4);
        fork
            begin
                issue("lim_issue4", 32'h1040, 8'd3);
                issue("lim_issue5", 32'h1050, 8'd3);
            end
            begin
                for (int b = 0; b < 24; b++) begin
                    if (b == 16) begin
                        for (int w = 0; w < 50 && (ar_total - base) != 6; w++) step();
                        chk("lim_ar_count6", ar_total - base, 6);
                    end
                    beat(32'h100 + 32'(b), (b % 4) == 3);
                    @(negedge clk);
                    step();
                end
                axi.rvalid = 1'b0;
            end
        join
        @(negedge clk);
        chk("lim_beats", rcv_data.size(), 24);
        lv = '0; bad = 0;
        for (int b = 0; b < 24; b++) begin
            lv[b] = rcv_last[b];
            if (rcv_data[b] !== 32'h100 + 32'(b)) bad++;
        end
        chk("lim_last_pattern", lv, 24'h888888);
        chk("lim_data_order", bad, 0);
        chk("lim_idle", idle, 1'b1);

        // Backpressure on AR and R
        step();
        rcv_data.delete(); rcv_last.delete();
        axi.arready = 1'b0;
        issue("bp_issue_a", 32'h2000, 8'd1);
        req_valid = 1'b1; req_addr = 32'h3000; req_len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_araddr_stable", axi.araddr, 32'h2000);
            chk("bp_req_ready", req_ready, 1'b0);
            step();
        end
        axi.arready = 1'b1;
        issue("bp_issue_b", 32'h3000, 8'd0);
        @(negedge clk);
        chk("bp_araddr_next", axi.araddr, 32'h3000);
        step();
        exp_d[0] = 32'hB0; exp_d[1] = 32'hB1; exp_d[2] = 32'hC0;
        exp_l[0] = 1'b0;   exp_l[1] = 1'b1;   exp_l[2] = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            rsp_ready = (c % 2) == 1;
            beat(exp_d[k], exp_l[k]);
            @(negedge clk);
            chk("bp_rready_mirror", axi.rready, rsp_ready);
            if (rsp_ready) k++;
            step();
        end
        axi.rvalid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk("bp_beats", rcv_data.size(), 3);
        for (int b = 0; b < 3; b++) begin
            chk("bp_data", rcv_data[b], exp_d[b]);
            chk("bp_last", rcv_last[b], exp_l[b]);
        end
        chk("bp_idle", idle, 1'b1);

        // AR handshake coinciding with a burst end
        step();
        issue("sim_issue_x", 32'h4000, 8'd1);
        step();
        axi.arready = 1'b0;
        issue("sim_issue_y", 32'h4100, 8'd2);
        beat(32'hD0, 1'b0);
        @(negedge clk);
        step();
        axi.arready = 1'b1;
        beat(32'hD1, 1'b1);
        @(negedge clk);
        chk("sim_x_last", rsp_last, 1'b1);
        step();
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("sim_outstanding", dut.outstanding_q, 1);
        chk("sim_arvalid", axi.arvalid, 1'b0);
        chk("sim_idle_busy", idle, 1'b0);
        step();
        for (int j = 0; j < 3; j++) begin
            beat(32'hE0 + 32'(j), j == 2);
            @(negedge clk);
            chk("sim_y_last", rsp_last, j == 2);
            if (j == 2) chk("sim_y_not_early", dut.outstanding_q, 1);
            step();
        end
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("sim_outstanding_end", dut.outstanding_q, 0);
        chk("sim_idle_done", idle, 1'b1);

        // Early rlast on a len 3 burst
        step();
        issue("mis_issue", 32'h5000, 8'd3);
        step();
        for (int j = 0; j < 4; j++) begin
            beat(32'hF0 + 32'(j), j == 1);
            @(negedge clk);
            chk("mis_rsp_resp", rsp_resp, (LC && (j == 1 || j == 3)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
            chk("mis_rsp_last", rsp_last, LC ? (j == 3) : (j == 1));
            if (j > 0) chk("mis_err_last", err_last, LC && (j == 2));
            step();
        end
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("mis_err_last_final", err_last, LC);
        chk("mis_idle", idle, 1'b1);
        step();
        @(negedge clk);
        chk("mis_err_pulse_end", err_last, 1'b0);

        // Reset with two bursts outstanding and an AR pending
        step();
        axi.arready = 1'b1;
        issue("rst_issue_a", 32'h6000, 8'd3);
        issue("rst_issue_b", 32'h6100, 8'd3);
        issue("rst_issue_c", 32'h6200, 8'd3);
        axi.arready = 1'b0;
        @(negedge clk);
        chk("mid_outstanding", dut.outstanding_q, 2);
        chk("mid_arvalid", axi.arvalid, 1'b1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("mid_rst_arvalid", axi.arvalid, 1'b0);
        chk("mid_rst_outstanding", dut.outstanding_q, 0);
        chk("mid_rst_idle", idle, 1'b1);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        step();
        rst_n = 1'b1;
        beat(32'h57A7, 1'b1);
        @(negedge clk);
        chk("stray_rsp_last", rsp_last, !LC);
        step();
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("stray_err_last", err_last, LC);
        chk("stray_outstanding", dut.outstanding_q, 0);
        chk("stray_idle", idle, 1'b1);
        step();
        axi.arready = 1'b1;
        issue("post_issue", 32'h7000, 8'd0);
        @(negedge clk);
        chk("post_arvalid", axi.arvalid, 1'b1);
        chk("post_araddr", axi.araddr, 32'h7000);
        step();
        beat(32'h600D, 1'b1);
        @(negedge clk);
        chk("post_rsp_data", rsp_data, 32'h600D);
        step();
        axi.rvalid = 1'b0;
        @(negedge clk);
        chk("post_idle", idle, 1'b1);
        chk("post_err_last", err_last, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
